// File: rtl/seven_seg_pkg.sv
// Shared constants, state encoding and sizing helper for the seven-segment scan controller.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_7seg_dec.sv
// BCD to active-low {g..a} segment decoder; codes 10-15 show the "0" glyph.
// Latency: purely combinational.
// Backpressure: none.
module bcd_to_7seg_dec
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode display scanner with double-buffered BCD input and leading-zero blanking.
// Latency: new data shows from digit 0 of the frame after the next frame boundary; pins are registered.
// Backpressure: none; load is always accepted and the latest load before a boundary wins.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic                  enable,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_done
);

  localparam int CW = clog2(SLOT_CYCLES);
  localparam int IW = (clog2(N_DIGITS) < 1) ? 1 : clog2(N_DIGITS);

  scan_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;

  logic [N_DIGITS-1:0][3:0] pend_bcd, act_bcd;
  logic [N_DIGITS-1:0]      pend_dp, act_dp;
  logic                     pend_vld;

  logic                frame_wrap;
  logic [N_DIGITS-1:0] supp;
  logic                zero_run;
  logic [6:0]          dec_seg;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic [N_DIGITS-1:0] an_d;
  logic                fd_d;

  assign frame_wrap = enable && (state == ST_SHOW) &&
                      (cnt == CW'(SLOT_CYCLES - 1)) && (idx == IW'(N_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      an_n       <= an_d;
      frame_done <= fd_d;
    end
  end

  // The slot counter runs straight through BLANK into SHOW, so one slot is SLOT_CYCLES long.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        ST_BLANK: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CW'(BLANK_CYCLES - 1)) state_nxt = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt == CW'(SLOT_CYCLES - 1)) begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
            idx_nxt   = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Pin registers are loaded from the next state so the pins line up with the state they show.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    fd_d  = 1'b0;
    if (state_nxt == ST_SHOW) begin
      an_d  = ~(N_DIGITS'(1) << idx_nxt);
      seg_d = supp[idx_nxt] ? SEG_BLANK : dec_seg;
      dp_d  = ~act_dp[idx_nxt];
      fd_d  = (cnt_nxt == CW'(SLOT_CYCLES - 1)) && (idx_nxt == IW'(N_DIGITS - 1));
    end
  end

  // A digit is blanked while it and everything above it is zero; digit 0 always shows.
  always_comb begin
    zero_run = lz_en;
    supp     = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (act_bcd[k] == 4'd0);
      supp[k]  = zero_run;
    end
  end

  bcd_to_7seg_dec u_dec (
    .bcd   (act_bcd[idx_nxt]),
    .seg_n (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bcd <= '0;
      pend_dp  <= '0;
      act_bcd  <= '0;
      act_dp   <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (frame_wrap && pend_vld) begin
        act_bcd <= pend_bcd;
        act_dp  <= pend_dp;
      end
      if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
      end
      if (load) pend_vld <= 1'b1;
      else if (frame_wrap) pend_vld <= 1'b0;
    end
  end

endmodule
